// File: rtl/alu_issue.sv
// alu_issue: 4-deep operation queue feeding a registered ALU, one operation in flight.
// Optional macro ALU_ISSUE_OPCHECK_EN rejects illegal opcodes and divide-by-zero before issue.
module alu_issue #(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_tag,
  output logic [4:0]        alu_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_tag,
  output logic              res_err,
  output logic [2:0]        fifo_level
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [4:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        tag;
  } entry_t;

  localparam logic [4:0] OP_IDLE = 5'b00000;

  state_t     state;
  entry_t     mem [4];
  entry_t     head;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic       head_bad;
  logic [3:0] iss_tag_p1;
  logic       iss_bad_p1;

`ifdef ALU_ISSUE_OPCHECK_EN
  function automatic logic op_ok(input logic [4:0] op, input logic [DATA_W-1:0] b);
    case (op)
      5'b00101, 5'b00111, 5'b00110, 5'b01000,
      5'b01011, 5'b10100, 5'b10101: op_ok = 1'b1;
      5'b01100:                     op_ok = (b != '0);
      default:                      op_ok = 1'b0;
    endcase
  endfunction

  assign head_bad = !op_ok(head.op, head.b);
`else
  assign head_bad = 1'b0;
`endif

  assign head       = mem[rd_ptr];
  assign in_ready   = (count < 3'd4);
  assign fifo_level = count;
  assign push       = in_valid && in_ready;
  assign pop        = (count != 3'd0) && ((state == IDLE) || (state == RESP && res_ready));

  // queue storage and issue-side tag/error capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end
    if (pop) begin
      iss_tag_p1 <= head.tag;
      iss_bad_p1 <= head_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      alu_s     <= OP_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= 4'd0;
      res_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      case (state)
        IDLE: ;
        ISSUE: begin
          alu_s <= OP_IDLE;
          if (iss_bad_p1) begin
            // rejected op skips the ALU entirely and reports an error
            res_valid <= 1'b1;
            res_data  <= '0;
            res_tag   <= iss_tag_p1;
            res_err   <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          res_valid <= 1'b1;
          res_data  <= alu_out;
          res_tag   <= iss_tag_p1;
          res_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // pop launches the head into ISSUE; overrides the IDLE fallback above
      if (pop) begin
        state <= ISSUE;
        if (head_bad) begin
          alu_s <= OP_IDLE;
        end else begin
          alu_s <= head.op;
          alu_a <= head.a;
          alu_b <= head.b;
        end
      end
    end
  end

endmodule
